// File: rtl/eth_tx_slot_tracker_if.sv
// ----------------------------------------------------------------------------
// eth_tx_slot_tracker_if
// Purpose : groups the MAC-side descriptor handshake and completion signals
//           of the TX slot tracker into one bundle.
// Signals :
//   tx_desc_v_o      descriptor valid toward the MAC
//   tx_desc_slot_o   slot index of the offered descriptor
//   tx_desc_len_o    packet length of the offered descriptor
//   tx_desc_ready_i  MAC accepts the descriptor (valid & ready handshake)
//   tx_done_i        1-cycle pulse, MAC finished the oldest issued packet
//   done_err_o       1-cycle pulse, completion arrived with nothing in flight
// Modports: master = tracker side, slave = MAC side.
// ----------------------------------------------------------------------------
interface eth_tx_slot_tracker_if #(
    parameter int slots_p     = 2,
    parameter int len_width_p = 11
);
    localparam int slot_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1;

    logic                     tx_desc_v_o;
    logic [slot_width_lp-1:0] tx_desc_slot_o;
    logic [len_width_p-1:0]   tx_desc_len_o;
    logic                     tx_desc_ready_i;
    logic                     tx_done_i;
    logic                     done_err_o;

    modport master (
        output tx_desc_v_o, tx_desc_slot_o, tx_desc_len_o, done_err_o,
        input  tx_desc_ready_i, tx_done_i
    );

    modport slave (
        input  tx_desc_v_o, tx_desc_slot_o, tx_desc_len_o, done_err_o,
        output tx_desc_ready_i, tx_done_i
    );
endinterface

// File: rtl/eth_tx_slot_tracker.sv
// ----------------------------------------------------------------------------
// eth_tx_slot_tracker
// Purpose : tracks Ethernet TX buffer slots between the CPU register side and
//           the TX MAC. Slots are filled, issued and retired strictly in
//           circular order, so three pointers plus two counters describe the
//           whole pipeline.
// Ports   :
//   clk_i         clock
//   reset_n_i     asynchronous active-low reset
//   fill_slot_o   slot the CPU must write packet data into next
//   send_v_i      CPU commits fill_slot_o with length send_len_i
//   send_len_i    packet length of the send command
//   send_err_o    1-cycle pulse, send rejected (full or illegal length)
//   packet_req_o  level, a free slot exists (feeds the TX interrupt)
//   occupied_o    committed + in-flight slot count
//   mac           MAC-side descriptor/completion bundle (master modport)
// ----------------------------------------------------------------------------
module eth_tx_slot_tracker #(
    parameter int slots_p     = 2,
    parameter int len_width_p = 11,
    parameter int max_len_p   = 1536,
    localparam int slot_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1,
    localparam int cnt_width_lp  = $clog2(slots_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    output logic [slot_width_lp-1:0] fill_slot_o,
    input  logic                     send_v_i,
    input  logic [len_width_p-1:0]   send_len_i,
    output logic                     send_err_o,
    output logic                     packet_req_o,
    output logic [cnt_width_lp-1:0]  occupied_o,
    eth_tx_slot_tracker_if.master    mac
);

    // One extra bit so the length limit compares without truncation.
    localparam logic [len_width_p:0] MaxLen = (len_width_p + 1)'(max_len_p);

    logic [slot_width_lp-1:0] r_fillPtr;
    logic [slot_width_lp-1:0] r_issuePtr;
    logic [slot_width_lp-1:0] r_retirePtr;
    logic [cnt_width_lp-1:0]  r_pend;
    logic [cnt_width_lp-1:0]  r_fly;
    logic                     r_sendErr;
    logic                     r_doneErr;
    logic [len_width_p-1:0]   r_lenMem [slots_p];

    logic w_lenOk;
    logic w_accept;
    logic w_issue;
    logic w_retire;
    logic [cnt_width_lp-1:0] w_occupied;

    // Event decode. Acceptance is gated by the registered free-slot level
    // only, so a completion in the same cycle cannot make room for a send.
    always_comb begin
        w_occupied = r_pend + r_fly;
        w_lenOk    = (send_len_i != '0) && ({1'b0, send_len_i} <= MaxLen);
        w_accept   = send_v_i && packet_req_o && w_lenOk;
        w_issue    = (r_pend != '0) && mac.tx_desc_ready_i;
        w_retire   = mac.tx_done_i && (r_fly != '0);
    end

    // Pointer and counter state. Counters take the net effect of all
    // events in the cycle; pointers wrap naturally since slots_p is a
    // power of two. Error pulses are registered one cycle behind the cause.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fillPtr   <= '0;
            r_issuePtr  <= '0;
            r_retirePtr <= '0;
            r_pend      <= '0;
            r_fly       <= '0;
            r_sendErr   <= 1'b0;
            r_doneErr   <= 1'b0;
        end else begin
            if (w_accept) r_fillPtr   <= r_fillPtr + slot_width_lp'(1);
            if (w_issue)  r_issuePtr  <= r_issuePtr + slot_width_lp'(1);
            if (w_retire) r_retirePtr <= r_retirePtr + slot_width_lp'(1);
            r_pend    <= r_pend + cnt_width_lp'(w_accept) - cnt_width_lp'(w_issue);
            r_fly     <= r_fly + cnt_width_lp'(w_issue) - cnt_width_lp'(w_retire);
            r_sendErr <= send_v_i && !w_accept;
            r_doneErr <= mac.tx_done_i && (r_fly == '0);
        end
    end

    // Length storage needs no reset: an entry is only read after a send
    // has written it.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_lenMem[r_fillPtr] <= send_len_i;
    end

    // All outputs come from registered state, so a reset clears them at once.
    always_comb begin
        fill_slot_o        = r_fillPtr;
        send_err_o         = r_sendErr;
        occupied_o         = w_occupied;
        packet_req_o       = (w_occupied < cnt_width_lp'(slots_p));
        mac.tx_desc_v_o    = (r_pend != '0);
        mac.tx_desc_slot_o = r_issuePtr;
        mac.tx_desc_len_o  = r_lenMem[r_issuePtr];
        mac.done_err_o     = r_doneErr;
    end

endmodule
